// File: rtl/key_evt_pkg.sv
// Shared types and helpers for the key event scheduler: event encodings,
// pending-slot layout and the key-index width function.
package key_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_REPEAT  = 2'b10
    } evt_type_e;

    // One-entry holding slot per key between the debouncer and the arbiter
    typedef struct packed {
        logic       pend;
        logic [1:0] typ;
    } slot_t;

    function automatic int kw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_event_scheduler_if.sv
// Event stream between the key scheduler (master) and its consumer (slave).
interface key_event_scheduler_if import key_evt_pkg::*; #(
    parameter int N_KEYS = 4,
    parameter int KW     = kw(N_KEYS)
) ();
    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_key;
    logic [1:0]    evt_type;
    logic          evt_overflow;
    logic          clr_overflow;

    modport master (
        output evt_valid, evt_key, evt_type, evt_overflow,
        input  evt_ready, clr_overflow
    );

    modport slave (
        input  evt_valid, evt_key, evt_type, evt_overflow,
        output evt_ready, clr_overflow
    );
endinterface

// File: rtl/key_debounce_chan.sv
// One key: 2-FF synchroniser, tick-based debounce and auto-repeat.
// Emits a combinational event strobe on the tick that changes state.
module key_debounce_chan import key_evt_pkg::*; #(
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_TICKS = 32,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_raw,
    input  logic       sample_tick,
    output logic       key_level,
    output logic       evt_raise,
    output logic [1:0] evt_type
);
    localparam int SW = $clog2(STABLE_TICKS + 1);
    localparam int RW = $clog2(REPEAT_TICKS + 1);

    logic [1:0]    sync_ff;
    logic          key_now;
    logic [SW-1:0] stable_cnt;
    logic [RW-1:0] repeat_cnt;
    logic          chg_done;
    logic          rep_done;

    assign key_now  = ACTIVE_LOW ? ~sync_ff[1] : sync_ff[1];
    assign chg_done = sample_tick && (key_now != key_level) &&
                      (stable_cnt == SW'(STABLE_TICKS - 1));
    assign rep_done = sample_tick && key_level && (key_now == key_level) &&
                      (repeat_cnt == RW'(REPEAT_TICKS - 1));

    assign evt_raise = chg_done || rep_done;
    assign evt_type  = chg_done ? (key_now ? EVT_PRESS : EVT_RELEASE) : EVT_REPEAT;

    // Synchroniser resets to the released level so reset never looks like a press
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff    <= {2{ACTIVE_LOW}};
            key_level  <= 1'b0;
            stable_cnt <= '0;
            repeat_cnt <= '0;
        end else begin
            sync_ff <= {sync_ff[0], key_raw};
            if (sample_tick) begin
                if (key_now != key_level) begin
                    if (chg_done) begin
                        key_level  <= key_now;
                        stable_cnt <= '0;
                        repeat_cnt <= '0;
                    end else begin
                        stable_cnt <= stable_cnt + 1'b1;
                    end
                end else begin
                    stable_cnt <= '0;
                    if (key_level)
                        repeat_cnt <= rep_done ? '0 : repeat_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/key_event_scheduler.sv
// Key front end: shared sample tick, per-key debounce channels, per-key
// pending slots and a round-robin arbiter feeding one registered event stream.
module key_event_scheduler import key_evt_pkg::*; #(
    parameter int N_KEYS       = 4,
    parameter int TICK_DIV     = 1048576,
    parameter int STABLE_TICKS = 2,
    parameter int REPEAT_TICKS = 32,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_KEYS-1:0]     key_in,
    output logic [N_KEYS-1:0]     key_level,
    key_event_scheduler_if.master evt
);
    localparam int KW = kw(N_KEYS);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0]            tick_cnt;
    logic                     sample_tick;
    logic [N_KEYS-1:0]        raise;
    logic [N_KEYS-1:0][1:0]   raise_type;
    slot_t [N_KEYS-1:0]       slot;
    logic [N_KEYS-1:0]        granted;
    logic [N_KEYS-1:0]        drop;
    logic [KW-1:0]            rr_ptr;
    logic [KW-1:0]            gnt_idx;
    logic [KW-1:0]            scan_idx;
    logic                     gnt_found;
    logic                     loadable;
    logic                     fire;

    function automatic logic [KW-1:0] wrap_add(input logic [KW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_KEYS) s -= N_KEYS;
        return KW'(s);
    endfunction

    assign sample_tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)              tick_cnt <= '0;
        else if (sample_tick) tick_cnt <= '0;
        else                  tick_cnt <= tick_cnt + 1'b1;
    end

    for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
        key_debounce_chan #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS),
            .ACTIVE_LOW   (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .key_raw     (key_in[k]),
            .sample_tick (sample_tick),
            .key_level   (key_level[k]),
            .evt_raise   (raise[k]),
            .evt_type    (raise_type[k])
        );
    end

    // First pending key at or after rr_ptr, wrapping around
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            scan_idx = wrap_add(rr_ptr, i);
            if (!gnt_found && slot[scan_idx].pend) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign loadable = !evt.evt_valid || evt.evt_ready;
    assign fire     = loadable && gnt_found;

    always_comb begin
        granted = '0;
        drop    = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            granted[k] = fire && (gnt_idx == KW'(k));
            drop[k]    = raise[k] && slot[k].pend && !granted[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt.evt_valid <= 1'b0;
            evt.evt_key   <= '0;
            evt.evt_type  <= '0;
            rr_ptr        <= '0;
        end else if (loadable) begin
            if (gnt_found) begin
                evt.evt_valid <= 1'b1;
                evt.evt_key   <= gnt_idx;
                evt.evt_type  <= slot[gnt_idx].typ;
                rr_ptr        <= wrap_add(gnt_idx, 1);
            end else begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

    // A slot granted this cycle may be refilled by a same-cycle event
    always_ff @(posedge clk) begin
        if (rst) begin
            slot             <= '0;
            evt.evt_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                if (raise[k] && !drop[k]) begin
                    slot[k].pend <= 1'b1;
                    slot[k].typ  <= raise_type[k];
                end else if (granted[k]) begin
                    slot[k].pend <= 1'b0;
                end
            end
            if (|drop)                 evt.evt_overflow <= 1'b1;
            else if (evt.clr_overflow) evt.evt_overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_event_scheduler.sv
// Bench for key_event_scheduler: table of key patterns plus hand sequences,
// events checked against a queue of expected {key,type}.
module tb_key_event_scheduler;
    import key_evt_pkg::*;

    localparam int N  = 4;
    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_in;
    logic [3:0] key_level;

    key_event_scheduler_if #(.N_KEYS(N)) evt_if ();

    key_event_scheduler #(
        .N_KEYS(N), .TICK_DIV(TD), .STABLE_TICKS(2), .REPEAT_TICKS(3), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level),
        .evt       (evt_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key_in;
        bit         bounce;
        int         ticks;
        logic [3:0] exp_level;
        bit         has_evt;
        logic [1:0] ekey;
        logic [1:0] etype;
        int         n_rep;
    } vec_t;

    vec_t       tbl [5];
    logic [3:0] exp_q [$];
    logic [3:0] exp_e;
    logic [3:0] prev_key;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_hs = 0;
    int         prev_hs = 0;
    bit         seen_ovf;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [1:0] k, input logic [1:0] t);
        exp_q.push_back({k, t});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
    endtask

    // Handshake monitor: valid&&ready seen here completes on the next posedge
    always begin
        @(negedge clk);
        #1;
        cyc++;
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got key %0d type %0d, expected none",
                         evt_if.evt_key, evt_if.evt_type);
            end else begin
                exp_e = exp_q.pop_front();
                check("event_key_type", int'({evt_if.evt_key, evt_if.evt_type}), int'(exp_e));
            end
            prev_hs = last_hs;
            last_hs = cyc;
        end
    end

    initial begin
        tbl[0] = '{4'hF,    1'b0, 25, 4'b0000, 1'b0, 2'd0, EVT_PRESS,   0};
        tbl[1] = '{4'b1101, 1'b1, 4,  4'b0010, 1'b1, 2'd1, EVT_PRESS,   0};
        tbl[2] = '{4'hF,    1'b1, 4,  4'b0000, 1'b1, 2'd1, EVT_RELEASE, 0};
        tbl[3] = '{4'b1011, 1'b0, 20, 4'b0100, 1'b1, 2'd2, EVT_PRESS,   6};
        tbl[4] = '{4'hF,    1'b0, 4,  4'b0000, 1'b1, 2'd2, EVT_RELEASE, 0};

        rst = 1'b1;
        key_in = 4'hF;
        evt_if.evt_ready = 1'b1;
        evt_if.clr_overflow = 1'b0;
        cycles(3);
        rst = 1'b0;
        check("rst_level", int'(key_level), 0);
        check("rst_valid", int'(evt_if.evt_valid), 0);
        check("rst_key", int'(evt_if.evt_key), 0);
        check("rst_type", int'(evt_if.evt_type), 0);
        check("rst_ovf", int'(evt_if.evt_overflow), 0);

        // Idle, bounce press/release, long hold with repeats
        prev_key = 4'hF;
        for (int v = 0; v < 5; v++) begin
            if (tbl[v].has_evt) push(tbl[v].ekey, tbl[v].etype);
            for (int r = 0; r < tbl[v].n_rep; r++) push(tbl[v].ekey, EVT_REPEAT);
            if (tbl[v].bounce) begin
                key_in = tbl[v].key_in;
                cycles(1);
                key_in = prev_key;
                cycles(1);
            end
            key_in = tbl[v].key_in;
            prev_key = tbl[v].key_in;
            cycles(tbl[v].ticks * TD);
            check($sformatf("level_v%0d", v), int'(key_level), int'(tbl[v].exp_level));
        end
        check("tbl_queue_drained", exp_q.size(), 0);

        // Simultaneous keys 0 and 3, round-robin order
        do_reset();
        push(2'd0, EVT_PRESS);
        push(2'd3, EVT_PRESS);
        key_in = 4'b0110;
        cycles(4 * TD);
        check("rr_level", int'(key_level), 9);
        check("rr_press_consec", last_hs - prev_hs, 1);
        check("rr_press_drained", exp_q.size(), 0);
        push(2'd0, EVT_RELEASE);
        push(2'd3, EVT_RELEASE);
        key_in = 4'hF;
        cycles(4 * TD);
        check("rr_release_consec", last_hs - prev_hs, 1);
        check("rr_release_drained", exp_q.size(), 0);

        // Backpressure, overflow, clear and set-beats-clear
        do_reset();
        evt_if.evt_ready = 1'b0;
        push(2'd0, EVT_PRESS);
        push(2'd0, EVT_REPEAT);
        key_in = 4'b1110;
        cycles(10 * TD);
        check("bp_mid_valid", int'(evt_if.evt_valid), 1);
        check("bp_mid_kt", int'({evt_if.evt_key, evt_if.evt_type}), 0);
        key_in = 4'hF;
        cycles(4 * TD);
        check("bp_valid", int'(evt_if.evt_valid), 1);
        check("bp_kt", int'({evt_if.evt_key, evt_if.evt_type}), 0);
        check("bp_ovf_set", int'(evt_if.evt_overflow), 1);
        evt_if.clr_overflow = 1'b1;
        cycles(1);
        evt_if.clr_overflow = 1'b0;
        check("ovf_cleared", int'(evt_if.evt_overflow), 0);
        evt_if.clr_overflow = 1'b1;
        key_in = 4'b1110;
        seen_ovf = 1'b0;
        repeat (10 * TD) begin
            @(negedge clk);
            if (evt_if.evt_overflow) seen_ovf = 1'b1;
        end
        key_in = 4'hF;
        cycles(4 * TD);
        evt_if.clr_overflow = 1'b0;
        cycles(1);
        check("ovf_set_wins", int'(seen_ovf), 1);
        check("ovf_clear_after", int'(evt_if.evt_overflow), 0);
        check("bp_held_kt", int'({evt_if.evt_valid, evt_if.evt_key, evt_if.evt_type}), 16);
        evt_if.evt_ready = 1'b1;
        cycles(10);
        check("bp_drained", exp_q.size(), 0);
        check("bp_idle_valid", int'(evt_if.evt_valid), 0);

        // Reset with key held and event waiting, then re-detection
        do_reset();
        evt_if.evt_ready = 1'b0;
        push(2'd1, EVT_PRESS);
        key_in = 4'b1101;
        cycles(4 * TD);
        check("prerst_valid", int'(evt_if.evt_valid), 1);
        rst = 1'b1;
        cycles(1);
        check("midrst_valid", int'(evt_if.evt_valid), 0);
        check("midrst_level", int'(key_level), 0);
        exp_q.delete();
        cycles(1);
        evt_if.evt_ready = 1'b1;
        push(2'd1, EVT_PRESS);
        rst = 1'b0;
        cycles(4 * TD);
        check("redetect_level", int'(key_level), 2);
        check("redetect_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
